// File: rtl/seq_hit_logger_pkg.sv
// Shared defaults and helpers for the hit logger: default widths/depth and a saturating increment.
package seq_hit_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  // Increments val, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/seq_hit_logger_if.sv
// Timestamp drain stream: head entry plus valid/ready; the logger is master, the consumer is slave.
interface seq_hit_logger_if
  import seq_hit_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);
  logic [TS_W-1:0] ts_rdata;
  logic            ts_valid;
  logic            ts_ready;

  modport master (output ts_rdata, output ts_valid, input ts_ready);
  modport slave  (input ts_rdata, input ts_valid, output ts_ready);
endinterface

// File: rtl/seq_hit_logger_fifo.sv
// Synchronous FIFO with registered head output; one-cycle push-to-visible latency.
// Push into a full FIFO is refused unless a pop happens on the same edge; clr empties it.
module seq_hit_fifo
  import seq_hit_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("seq_hit_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Preload the next head; if that slot is being written this edge, forward the incoming data.
      if (rd_ptr_d != wr_ptr_d) begin
        if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) dout_d = din;
        else                                                  dout_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/seq_hit_logger.sv
// Counts and timestamps detector hits into a FIFO drained over valid/ready; a hit seen at edge N is visible after edge N.
// A hit into a full FIFO with no pop is dropped and sets sticky overflow; SEQ_HIT_LOGGER_DROP_CNT_EN adds a drop counter.
module seq_hit_logger
  import seq_hit_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                hit,
  seq_hit_logger_if.master    ts_if,
  output logic [CNT_W-1:0]    hit_cnt,
`ifdef SEQ_HIT_LOGGER_DROP_CNT_EN
  output logic [7:0]          drop_cnt,
`endif
  output logic                fifo_full,
  output logic                overflow
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             overflow_q, overflow_d;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  assign pop  = ts_if.ts_valid && ts_if.ts_ready;
  assign drop = hit && fifo_full && !pop && !clr;

  seq_hit_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (hit),
    .din   (ts_q),
    .pop   (pop),
    .dout  (ts_if.ts_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ts_if.ts_valid = !fifo_empty;
  assign hit_cnt        = hit_cnt_q;
  assign overflow       = overflow_q;

  always_comb begin
    ts_d       = ts_q + 1'b1;
    hit_cnt_d  = hit_cnt_q;
    overflow_d = overflow_q | drop;
    if (hit) hit_cnt_d = CNT_W'(sat_inc(64'(hit_cnt_q), CNT_W));
    if (clr) begin
      ts_d       = '0;
      hit_cnt_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      hit_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      hit_cnt_q  <= hit_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SEQ_HIT_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr)       drop_cnt_d = '0;
    else if (drop) drop_cnt_d = 8'(sat_inc(64'(drop_cnt_q), 8));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end
`endif

endmodule

// File: tb/tb_seq_hit_logger.sv
// Directed bench for seq_hit_logger: stimulus queues expected timestamps, a negedge monitor checks each drained entry.
module tb_seq_hit_logger;
  import seq_hit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        hit;
  logic [15:0] hit_cnt;
  logic        fifo_full;
  logic        overflow;
`ifdef SEQ_HIT_LOGGER_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  seq_hit_logger_if #(.TS_W(16)) ts_if ();

  seq_hit_logger #(.TS_W(16), .CNT_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .hit       (hit),
    .ts_if     (ts_if),
    .hit_cnt   (hit_cnt),
`ifdef SEQ_HIT_LOGGER_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs are applied just after a rising edge and take effect at the following edge.
  task automatic cyc(input logic h, input logic r, input logic c);
    hit = h;
    ts_if.ts_ready = r;
    clr = c;
    @(posedge clk);
    #1;
    hit = 1'b0;
    ts_if.ts_ready = 1'b0;
    clr = 1'b0;
  endtask

  task automatic hit_exp(input logic [15:0] ts);
    cyc(1'b1, 1'b0, 1'b0);
    exp_q.push_back(ts);
  endtask

  always @(negedge clk) begin
    if (!rst && ts_if.ts_valid && ts_if.ts_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pop: got %0d expected no entry", ts_if.ts_rdata);
      end else begin
        chk("ts_rdata", 32'(ts_if.ts_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    hit = 1'b0;
    ts_if.ts_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(ts_if.ts_valid), 0);
    chk("rst_rdata", 32'(ts_if.ts_rdata), 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;

    // Single hit at cycle 5 after reset release.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    hit_exp(16'd5);
    chk("t1_valid", 32'(ts_if.ts_valid), 1);
    chk("t1_hit_cnt", 32'(hit_cnt), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t1_empty", 32'(ts_if.ts_valid), 0);

    // Hits at 2,4,6,8,10 with no drain: fourth fills, fifth drops.
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 10; k++) begin
      if (k >= 2 && k % 2 == 0 && k <= 8) hit_exp(16'(k));
      else cyc(k == 10, 1'b0, 1'b0);
      if (k == 8) begin
        chk("t2_full", 32'(fifo_full), 1);
        chk("t2_no_ovf_yet", 32'(overflow), 0);
      end
    end
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_hit_cnt", 32'(hit_cnt), 5);
`ifdef SEQ_HIT_LOGGER_DROP_CNT_EN
    chk("t2_drop_cnt", 32'(drop_cnt), 1);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("t2_drained", 32'(ts_if.ts_valid), 0);
    chk("t2_ovf_sticky", 32'(overflow), 1);

    // Full FIFO with simultaneous pop and push.
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) hit_exp(16'(k));
    chk("t3_full", 32'(fifo_full), 1);
    cyc(1'b1, 1'b1, 1'b0);
    exp_q.push_back(16'd4);
    chk("t3_still_full", 32'(fifo_full), 1);
    chk("t3_overflow", 32'(overflow), 0);
    chk("t3_hit_cnt", 32'(hit_cnt), 5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("t3_drained", 32'(ts_if.ts_valid), 0);

    // Timestamp wrap.
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65534; i++) cyc(1'b0, 1'b0, 1'b0);
    hit_exp(16'd65534);
    hit_exp(16'd65535);
    hit_exp(16'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("t4_drained", 32'(ts_if.ts_valid), 0);

    // Clear coincident with a hit while two entries are held and overflow is set.
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) hit_exp(16'(k));
    cyc(1'b1, 1'b0, 1'b0);
    chk("t5_overflow", 32'(overflow), 1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    exp_q.delete();
    chk("t5_valid", 32'(ts_if.ts_valid), 0);
    chk("t5_hit_cnt", 32'(hit_cnt), 0);
    chk("t5_overflow_clr", 32'(overflow), 0);
    chk("t5_full", 32'(fifo_full), 0);
`ifdef SEQ_HIT_LOGGER_DROP_CNT_EN
    chk("t5_drop_cnt", 32'(drop_cnt), 0);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    hit_exp(16'd1);
    chk("t5_restart_valid", 32'(ts_if.ts_valid), 1);
    cyc(1'b0, 1'b1, 1'b0);

    // Asynchronous reset with three entries queued.
    for (int k = 0; k < 3; k++) hit_exp(16'(k + 3));
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_valid", 32'(ts_if.ts_valid), 0);
    chk("t6_hit_cnt", 32'(hit_cnt), 0);
    chk("t6_full", 32'(fifo_full), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    hit_exp(16'd1);
    chk("t6_hit_cnt_after", 32'(hit_cnt), 1);
    cyc(1'b0, 1'b1, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_hit_logger.md
Name: seq_hit_logger

Overview:
- Downstream consumer of the serial sequence detector's single-cycle Moore match output (`hit`).
- Counts matches and timestamps each one with a free-running cycle counter.
- Buffers the timestamps in a small FIFO that a host or next stage drains through a valid/ready interface.
- Flags lost events when the FIFO overflows.

Parameters:
- TS_W, 16, width of the free-running timestamp and of each FIFO entry.
- CNT_W, 16, width of the total-hit counter.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of counters, FIFO and flags.
- hit  in  1  detector match; each cycle sampled high is one event.
- ts_rdata  out  TS_W  timestamp at the FIFO head.
- ts_valid  out  1  FIFO non-empty.
- ts_ready  in  1  consumer accepts the head entry.
- hit_cnt  out  CNT_W  total hits seen, saturating.
- fifo_full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; at least one hit was dropped.

Behaviour:
- Reset (rst=1, async): timestamp=0, hit_cnt=0, FIFO empty, ts_valid=0, ts_rdata=0, fifo_full=0, overflow=0.
- Timestamp:
  - Increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
  - The value pushed for a hit is the timestamp before that edge's increment.
- Push and hit_cnt:
  - hit=1 at a rising edge pushes the current timestamp.
  - hit_cnt increments by 1 and holds at 2^CNT_W-1.
- Pop:
  - Occurs when ts_valid && ts_ready at a rising edge.
  - ts_rdata is the head entry, driven from FIFO storage with no combinational path from hit.
  - ts_rdata holds its last value when the FIFO is empty.
- Latency: a hit sampled at edge N gives ts_valid=1 after edge N, with ts_rdata equal to the pushed timestamp.
- Empty FIFO, hit in the same cycle: no pop is possible because ts_valid=0. The entry appears next cycle.
- Full FIFO, hit with pop in the same cycle: both succeed, occupancy stays DEPTH, fifo_full stays 1.
- Full FIFO, hit without pop: the entry is dropped.
  - hit_cnt still increments.
  - overflow is set and stays 1 until clr or rst.
- clr=1:
  - Next edge: timestamp=0, hit_cnt=0, FIFO empty, overflow=0.
  - clr takes priority: a hit or pop in the same cycle is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked with an extra pointer bit, so full and empty are distinguished.
- Reset mid-operation discards all FIFO contents. Storage need not be cleared, but ts_valid must be 0.

Optional Feature:
- Macro: SEQ_HIT_LOGGER_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt (8 bits, saturating at 255).
  - drop_cnt counts hits dropped on overflow.
  - Reset and clr set it to 0.
- When undefined: the port and its logic are absent, and overflow is the only loss indication.

Decomposition:
- Package seq_hit_pkg holds:
  - default widths TS_W_DEF=16, CNT_W_DEF=16, DEPTH_DEF=4;
  - a saturating-increment helper function.
- One sub-module: seq_hit_fifo, a synchronous FIFO with push/pop, full/empty, sync clear and async reset.
- The top holds the timestamp, hit counter, overflow and drop logic.

Test Plan:
- Release rst at cycle 0, hold ts_ready=0, pulse hit at cycle 5 -> next cycle ts_valid=1, ts_rdata=5, hit_cnt=1.
- hit at cycles 2, 4, 6, 8, 10 with ts_ready=0, DEPTH=4:
  - fifo_full=1 after the 4th push;
  - 5th hit dropped: overflow=1, hit_cnt=5, with the macro drop_cnt=1;
  - draining gives 2, 4, 6, 8.
- FIFO full and ts_ready=1 in the same cycle as hit=1 -> the pop and push both occur, fifo_full stays 1, overflow stays 0.
- Force the timestamp near wrap by running 65534 cycles, then hit on two consecutive cycles -> entries 65534 and 65535; a following hit one cycle later logs 0.
- clr=1 coincident with hit=1 while holding 2 entries -> next cycle ts_valid=0, hit_cnt=0, overflow=0, timestamp restarts at 0.
- Assert rst asynchronously mid-cycle with 3 entries queued -> immediately ts_valid=0, hit_cnt=0, fifo_full=0.
